ibex_wb_buffer: RTL and testbench
=================================

Name: ibex_wb_buffer

Overview:
- Single-entry writeback stage directly downstream of the execution block.
- Captures the EX result (ALU/mult-div result or pending load) with its destination register, and drives the register-file write port.
- Load entries wait for the LSU response, whose data is byte-aligned and sign- or zero-extended here before write.
- Provides a forwarding path to ID and a retire pulse for performance counting.

Parameters:
- ResetAll, 0, 1: data/address registers are also reset. 0: only the valid/state flops are reset.
- RetireCntW, 16, width of the saturating retired-instruction counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- ex_valid_i  in  1  EX stage has a valid output this cycle
- ex_result_i  in  32  EX result
- ex_rd_addr_i  in  5  destination register
- ex_rd_we_i  in  1  instruction writes rd
- ex_is_load_i  in  1  instruction is a load; data comes from LSU
- ex_load_type_i  in  2  00 word, 01 half, 10 byte
- ex_load_sext_i  in  1  sign-extend load data
- ex_addr_lsb_i  in  2  load address bits [1:0], from the EX adder result
- wb_ready_o  out  1  buffer can accept an entry this cycle
- lsu_resp_valid_i  in  1  LSU response valid
- lsu_resp_rdata_i  in  32  raw aligned-word read data
- lsu_resp_err_i  in  1  load bus error
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- fwd_valid_o  out  1  forwarding data valid
- fwd_addr_o  out  5  forwarding register address
- fwd_data_o  out  32  forwarding data
- load_err_o  out  1  one-cycle pulse on a load error
- instr_ret_o  out  1  one-cycle retire pulse
- retire_cnt_o  out  RetireCntW  saturating count of retired instructions

Behaviour:
- Clock and reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.
- State machine states: EMPTY, FULL_DONE, FULL_LOAD.
- Reset values:
  - State is EMPTY.
  - All outputs are 0, except `wb_ready_o`, which is 1.
  - `retire_cnt_o` is 0.
  - A reset mid-load discards the entry. A late `lsu_resp_valid_i` is then ignored while EMPTY.
- Accept:
  - Condition: `ex_valid_i && wb_ready_o`.
  - `wb_ready_o` = (state==EMPTY) || (state==FULL_DONE) || (state==FULL_LOAD && lsu_resp_valid_i).
  - This is a combinational pass-through, so back-to-back accepts run at one per cycle.
  - Captured entry: `ex_result_i`, rd, we, load attributes.
  - Next state: FULL_LOAD if `ex_is_load_i`, else FULL_DONE.
- FULL_DONE (one cycle):
  - `rf_we_o` = rd_we && (rd != 0).
  - `rf_wdata_o` = captured result.
  - `instr_ret_o` = 1.
  - Next state: FULL_DONE/FULL_LOAD on a new accept, else EMPTY.
- FULL_LOAD:
  - Holds until `lsu_resp_valid_i`.
  - In the response cycle with no error: `rf_we_o` = rd_we && rd!=0, `rf_wdata_o` = extended data, `instr_ret_o` = 1.
  - With `lsu_resp_err_i`: `rf_we_o` = 0, `load_err_o` = 1, `instr_ret_o` = 0.
  - Exit follows the same accept rule as FULL_DONE.
- Load extension:
  - Word: data passed unchanged; `ex_addr_lsb_i` is ignored.
  - Half: select `rdata[16*lsb[1] +: 16]`; `lsb[0]` is ignored.
  - Byte: select `rdata[8*lsb +: 8]`.
  - Upper bits are filled with the selected MSB if sext, else 0.
  - Load type 11 is treated as word.
- Forwarding:
  - `fwd_valid_o` = `rf_we_o`; `fwd_addr_o`/`fwd_data_o` equal the RF write values.
  - No forwarding while in FULL_LOAD before the response arrives.
- x0 entries still retire, but never assert `rf_we_o`.
- `retire_cnt_o` increments on `instr_ret_o` and saturates at all-ones.
- `lsu_resp_valid_i` is ignored in EMPTY and FULL_DONE.
- Simultaneous response and accept: the old entry writes and the new entry is captured in the same cycle.

Test Plan:
- ALU retire: accept result=0x1234_5678, rd=5, we=1 → next cycle `rf_we_o`=1, waddr=5, wdata=0x1234_5678, `instr_ret_o`=1, `retire_cnt_o`=1.
- Signed byte load: rd=3, byte, sext, lsb=2, response 0x0080_0000 → wdata=0xFFFF_FF80. Repeat with zero-extend → 0x0000_0080.
- Half load: lsb=2, rdata=0xABCD_0000, sext → 0xFFFF_ABCD. Word load with lsb ignored → 0xABCD_0000.
- Load stall: response arrives 3 cycles late → `wb_ready_o`=0 and `fwd_valid_o`=0 for 3 cycles. On the response cycle the write occurs and a pending ALU op is accepted in that same cycle.
- Error and x0: `lsu_resp_err_i`=1 → `load_err_o`=1, no write, no retire. ALU op with rd=0 → `rf_we_o`=0, `instr_ret_o`=1.
- Reset mid-load, then saturation: with FULL_LOAD pending, assert `rst_i` → EMPTY and outputs 0; a response the following cycle is ignored. Separately, drive 2^16 retires → `retire_cnt_o` holds 0xFFFF.

Source files
------------

// File: rtl/ibex_wb_buffer.sv
// Single-entry writeback buffer between EX and the register file.
// Holds one ALU result or pending load, aligns/extends load data, and drives RF write, forwarding and retire.
module ibex_wb_buffer #(
  parameter bit          ResetAll   = 1'b0,
  parameter int unsigned RetireCntW = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  input  logic [31:0]           ex_result_i,
  input  logic [4:0]            ex_rd_addr_i,
  input  logic                  ex_rd_we_i,
  input  logic                  ex_is_load_i,
  input  logic [1:0]            ex_load_type_i,
  input  logic                  ex_load_sext_i,
  input  logic [1:0]            ex_addr_lsb_i,
  output logic                  wb_ready_o,
  input  logic                  lsu_resp_valid_i,
  input  logic [31:0]           lsu_resp_rdata_i,
  input  logic                  lsu_resp_err_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [31:0]           rf_wdata_o,
  output logic                  fwd_valid_o,
  output logic [4:0]            fwd_addr_o,
  output logic [31:0]           fwd_data_o,
  output logic                  load_err_o,
  output logic                  instr_ret_o,
  output logic [RetireCntW-1:0] retire_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY     = 2'b00,
    FULL_DONE = 2'b01,
    FULL_LOAD = 2'b10
  } wb_state_e;

  wb_state_e             state_r;
  wb_state_e             state_s;
  logic [31:0]           result_r;
  logic [4:0]            rd_addr_r;
  logic                  rd_we_r;
  logic [1:0]            load_type_r;
  logic                  load_sext_r;
  logic [1:0]            addr_lsb_r;
  logic [RetireCntW-1:0] retire_cnt_r;
  logic                  wb_ready_s;
  logic                  accept_s;
  logic                  rf_we_s;
  logic [31:0]           rf_wdata_s;
  logic                  load_err_s;
  logic                  instr_ret_s;

  // Select the addressed half/byte of the response word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [1:0]  load_type,
                                              input logic        sext,
                                              input logic [1:0]  lsb,
                                              input logic [31:0] rdata);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res_v;
    half_v = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (lsb)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (load_type)
      2'b01:   res_v = {{16{sext & half_v[15]}}, half_v};
      2'b10:   res_v = {{24{sext & byte_v[7]}}, byte_v};
      default: res_v = rdata;
    endcase
    return res_v;
  endfunction

  // Ready, next state and writeback outputs, all decoded from the held entry and the LSU response.
  always_comb begin
    wb_ready_s  = 1'b1;
    state_s     = EMPTY;
    rf_we_s     = 1'b0;
    rf_wdata_s  = 32'd0;
    load_err_s  = 1'b0;
    instr_ret_s = 1'b0;
    case (state_r)
      FULL_DONE: begin
        rf_we_s     = rd_we_r && (rd_addr_r != 5'd0);
        rf_wdata_s  = result_r;
        instr_ret_s = 1'b1;
      end
      FULL_LOAD: begin
        wb_ready_s = lsu_resp_valid_i;
        if (!lsu_resp_valid_i) begin
          state_s = FULL_LOAD;
        end else if (lsu_resp_err_i) begin
          load_err_s = 1'b1;
        end else begin
          rf_we_s     = rd_we_r && (rd_addr_r != 5'd0);
          rf_wdata_s  = load_extend(load_type_r, load_sext_r, addr_lsb_r, lsu_resp_rdata_i);
          instr_ret_s = 1'b1;
        end
      end
      default: begin
        wb_ready_s = 1'b1;
      end
    endcase
    accept_s = ex_valid_i && wb_ready_s;
    if (accept_s) begin
      state_s = ex_is_load_i ? FULL_LOAD : FULL_DONE;
    end else begin
      state_s = state_s;
    end
  end

  // State register; a reset discards any held entry, including an outstanding load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Entry payload; only cleared on reset when ResetAll is set.
  always_ff @(posedge clk_i) begin
    if (rst_i && ResetAll) begin
      result_r    <= 32'd0;
      rd_addr_r   <= 5'd0;
      rd_we_r     <= 1'b0;
      load_type_r <= 2'b00;
      load_sext_r <= 1'b0;
      addr_lsb_r  <= 2'b00;
    end else if (accept_s) begin
      result_r    <= ex_result_i;
      rd_addr_r   <= ex_rd_addr_i;
      rd_we_r     <= ex_rd_we_i;
      load_type_r <= ex_load_type_i;
      load_sext_r <= ex_load_sext_i;
      addr_lsb_r  <= ex_addr_lsb_i;
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retire_cnt_r <= {RetireCntW{1'b0}};
    end else if (instr_ret_s && (retire_cnt_r != {RetireCntW{1'b1}})) begin
      retire_cnt_r <= retire_cnt_r + {{(RetireCntW-1){1'b0}}, 1'b1};
    end
  end

  assign wb_ready_o   = wb_ready_s;
  assign rf_we_o      = rf_we_s;
  assign rf_waddr_o   = (state_r == EMPTY) ? 5'd0 : rd_addr_r;
  assign rf_wdata_o   = rf_wdata_s;
  assign fwd_valid_o  = rf_we_s;
  assign fwd_addr_o   = rf_waddr_o;
  assign fwd_data_o   = rf_wdata_s;
  assign load_err_o   = load_err_s;
  assign instr_ret_o  = instr_ret_s;
  assign retire_cnt_o = retire_cnt_r;

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// Bench for ibex_wb_buffer: directed scenarios plus random traffic against a pending-slot reference model.
module tb_ibex_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [31:0] ex_result_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_rd_we_i;
  logic        ex_is_load_i;
  logic [1:0]  ex_load_type_i;
  logic        ex_load_sext_i;
  logic [1:0]  ex_addr_lsb_i;
  logic        wb_ready_o;
  logic        lsu_resp_valid_i;
  logic [31:0] lsu_resp_rdata_i;
  logic        lsu_resp_err_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
  logic        load_err_o;
  logic        instr_ret_o;
  logic [15:0] retire_cnt_o;

  ibex_wb_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i), .ex_is_load_i(ex_is_load_i),
    .ex_load_type_i(ex_load_type_i), .ex_load_sext_i(ex_load_sext_i), .ex_addr_lsb_i(ex_addr_lsb_i),
    .wb_ready_o(wb_ready_o), .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_rdata_i(lsu_resp_rdata_i),
    .lsu_resp_err_i(lsu_resp_err_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .load_err_o(load_err_o), .instr_ret_o(instr_ret_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: at most one pending instruction plus a retire tally.
  bit          m_has;
  bit          m_load;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [1:0]  m_type;
  bit          m_sext;
  logic [1:0]  m_lsb;
  int          m_cnt;

  function automatic logic [31:0] extract(input logic [1:0] ltype, input bit sext,
                                          input logic [1:0] lsb, input logic [31:0] rdata);
    int unsigned v;
    int unsigned w;
    if (ltype == 2'd1) begin
      w = 16;
      v = (rdata >> (16 * int'(lsb[1]))) & 32'h0000_FFFF;
    end else if (ltype == 2'd2) begin
      w = 8;
      v = (rdata >> (8 * int'(lsb))) & 32'h0000_00FF;
    end else begin
      return rdata;
    end
    if (sext && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle();
    bit          e_ready, e_ret, e_we, e_err, done;
    logic [31:0] e_data;
    #1;
    e_ready = !m_has || !m_load || lsu_resp_valid_i;
    done    = m_has && (!m_load || lsu_resp_valid_i);
    e_ret = 0; e_we = 0; e_err = 0; e_data = 32'd0;
    if (done) begin
      if (m_load && lsu_resp_err_i) e_err = 1;
      else begin
        e_ret  = 1;
        e_we   = m_we && (m_rd != 5'd0);
        e_data = m_load ? extract(m_type, m_sext, m_lsb, lsu_resp_rdata_i) : m_res;
      end
    end
    chk("ready", {31'd0, wb_ready_o}, {31'd0, e_ready});
    chk("rf_we", {31'd0, rf_we_o}, {31'd0, e_we});
    chk("fwd_valid", {31'd0, fwd_valid_o}, {31'd0, e_we});
    chk("load_err", {31'd0, load_err_o}, {31'd0, e_err});
    chk("instr_ret", {31'd0, instr_ret_o}, {31'd0, e_ret});
    chk("retire_cnt", {16'd0, retire_cnt_o}, m_cnt);
    if (e_we) begin
      chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_rd});
      chk("rf_wdata", rf_wdata_o, e_data);
      chk("fwd_addr", {27'd0, fwd_addr_o}, {27'd0, m_rd});
      chk("fwd_data", fwd_data_o, e_data);
    end
    @(posedge clk_i);
    if (rst_i) begin
      m_has = 0;
      m_cnt = 0;
    end else begin
      if (e_ret && m_cnt < 65535) m_cnt++;
      if (ex_valid_i && e_ready) begin
        m_has = 1; m_load = ex_is_load_i; m_res = ex_result_i; m_rd = ex_rd_addr_i;
        m_we = ex_rd_we_i; m_type = ex_load_type_i; m_sext = ex_load_sext_i; m_lsb = ex_addr_lsb_i;
      end else if (done) begin
        m_has = 0;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic drv_alu(input logic [31:0] res, input logic [4:0] rd, input bit we);
    ex_valid_i = 1'b1; ex_result_i = res; ex_rd_addr_i = rd; ex_rd_we_i = we; ex_is_load_i = 1'b0;
  endtask

  task automatic drv_load(input logic [4:0] rd, input logic [1:0] lt, input bit sx, input logic [1:0] lsb);
    ex_valid_i = 1'b1; ex_result_i = 32'h0000_1000; ex_rd_addr_i = rd; ex_rd_we_i = 1'b1;
    ex_is_load_i = 1'b1; ex_load_type_i = lt; ex_load_sext_i = sx; ex_addr_lsb_i = lsb;
  endtask

  task automatic respond(input logic [31:0] rdata, input bit err);
    ex_valid_i = 1'b0; lsu_resp_valid_i = 1'b1; lsu_resp_rdata_i = rdata; lsu_resp_err_i = err;
  endtask

  initial begin
    rst_i = 1'b1; ex_valid_i = 1'b0; ex_result_i = 32'd0; ex_rd_addr_i = 5'd0; ex_rd_we_i = 1'b0;
    ex_is_load_i = 1'b0; ex_load_type_i = 2'd0; ex_load_sext_i = 1'b0; ex_addr_lsb_i = 2'd0;
    lsu_resp_valid_i = 1'b0; lsu_resp_rdata_i = 32'd0; lsu_resp_err_i = 1'b0;
    m_has = 0; m_load = 0; m_res = 32'd0; m_rd = 5'd0; m_we = 0; m_type = 2'd0; m_sext = 0;
    m_lsb = 2'd0; m_cnt = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_ready", {31'd0, wb_ready_o}, 32'd1);
    chk("reset_rf_we", {31'd0, rf_we_o}, 32'd0);
    chk("reset_cnt", {16'd0, retire_cnt_o}, 32'd0);
    cycle();

    // ALU retire
    drv_alu(32'h1234_5678, 5'd5, 1'b1); cycle();
    ex_valid_i = 1'b0; #1;
    chk("alu_we", {31'd0, rf_we_o}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr_o}, 32'd5);
    chk("alu_wdata", rf_wdata_o, 32'h1234_5678);
    chk("alu_ret", {31'd0, instr_ret_o}, 32'd1);
    cycle();
    chk("alu_cnt", {16'd0, retire_cnt_o}, 32'd1);

    // Byte loads, signed then unsigned
    drv_load(5'd3, 2'b10, 1'b1, 2'd2); cycle();
    respond(32'h0080_0000, 1'b0); #1;
    chk("lb_sext", rf_wdata_o, 32'hFFFF_FF80);
    cycle();
    lsu_resp_valid_i = 1'b0;
    drv_load(5'd3, 2'b10, 1'b0, 2'd2); cycle();
    respond(32'h0080_0000, 1'b0); #1;
    chk("lb_zext", rf_wdata_o, 32'h0000_0080);
    cycle();
    lsu_resp_valid_i = 1'b0;

    // Half and word loads
    drv_load(5'd8, 2'b01, 1'b1, 2'd2); cycle();
    respond(32'hABCD_0000, 1'b0); #1;
    chk("lh_sext", rf_wdata_o, 32'hFFFF_ABCD);
    cycle();
    lsu_resp_valid_i = 1'b0;
    drv_load(5'd8, 2'b00, 1'b1, 2'd3); cycle();
    respond(32'hABCD_0000, 1'b0); #1;
    chk("lw", rf_wdata_o, 32'hABCD_0000);
    cycle();
    lsu_resp_valid_i = 1'b0;

    // Load stall, then response with a same-cycle accept
    drv_load(5'd7, 2'b00, 1'b0, 2'd0); cycle();
    drv_alu(32'h0000_00A5, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", {31'd0, wb_ready_o}, 32'd0);
      chk("stall_fwd", {31'd0, fwd_valid_o}, 32'd0);
      cycle();
    end
    lsu_resp_valid_i = 1'b1; lsu_resp_rdata_i = 32'h0000_CAFE; #1;
    chk("resp_we", {31'd0, rf_we_o}, 32'd1);
    chk("resp_ready", {31'd0, wb_ready_o}, 32'd1);
    chk("resp_wdata", rf_wdata_o, 32'h0000_CAFE);
    cycle();
    ex_valid_i = 1'b0; lsu_resp_valid_i = 1'b0; #1;
    chk("pending_waddr", {27'd0, rf_waddr_o}, 32'd9);
    chk("pending_wdata", rf_wdata_o, 32'h0000_00A5);
    cycle();

    // Load error, then x0 ALU op
    drv_load(5'd4, 2'b00, 1'b0, 2'd0); cycle();
    respond(32'h1111_1111, 1'b1); #1;
    chk("err_pulse", {31'd0, load_err_o}, 32'd1);
    chk("err_we", {31'd0, rf_we_o}, 32'd0);
    chk("err_ret", {31'd0, instr_ret_o}, 32'd0);
    cycle();
    lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
    drv_alu(32'hDEAD_BEEF, 5'd0, 1'b1); cycle();
    ex_valid_i = 1'b0; #1;
    chk("x0_we", {31'd0, rf_we_o}, 32'd0);
    chk("x0_ret", {31'd0, instr_ret_o}, 32'd1);
    cycle();

    // Reset mid-load; a late response must be ignored
    drv_load(5'd6, 2'b00, 1'b0, 2'd0); cycle();
    ex_valid_i = 1'b0; rst_i = 1'b1; cycle();
    rst_i = 1'b0;
    respond(32'h5555_AAAA, 1'b0); #1;
    chk("rst_late_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_late_ret", {31'd0, instr_ret_o}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready_o}, 32'd1);
    chk("rst_cnt", {16'd0, retire_cnt_o}, 32'd0);
    cycle();
    lsu_resp_valid_i = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i            = ($urandom_range(0, 199) == 0);
      ex_valid_i       = ($urandom_range(0, 99) < 60);
      ex_result_i      = $urandom;
      ex_rd_addr_i     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ex_rd_we_i       = ($urandom_range(0, 9) != 0);
      ex_is_load_i     = $urandom_range(0, 1);
      ex_load_type_i   = 2'($urandom);
      ex_load_sext_i   = $urandom_range(0, 1);
      ex_addr_lsb_i    = 2'($urandom);
      lsu_resp_valid_i = ($urandom_range(0, 99) < 40);
      lsu_resp_rdata_i = $urandom;
      lsu_resp_err_i   = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Counter saturation
    rst_i = 1'b1; ex_valid_i = 1'b0; lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
    cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      drv_alu(i, 5'd1, 1'b1);
      cycle();
    end
    ex_valid_i = 1'b0;
    cycle();
    chk("sat_cnt", {16'd0, retire_cnt_o}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
